// File: rtl/repl_policy_array.sv
// Per-set cache replacement policy: true-LRU precedence matrix (MODE 0) or round-robin pointer
// (MODE 1), with a post-reset initialisation sweep and a registered victim query port.
module repl_policy_array #(
  parameter int N_WAYS = 4,
  parameter int N_SETS = 64,
  parameter int MODE   = 0
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      ENB,
  input  logic                      TOUCH_VLD,
  input  logic [$clog2(N_SETS)-1:0] TOUCH_SET,
  input  logic [N_WAYS-1:0]         TOUCH_WAY,
  input  logic                      VICT_REQ,
  input  logic [$clog2(N_SETS)-1:0] VICT_SET,
  input  logic [N_WAYS-1:0]         LOCK,
  output logic                      VICT_VLD,
  output logic [N_WAYS-1:0]         VICT_WAY,
  output logic                      INIT_DONE
);
  localparam int SET_W = $clog2(N_SETS);
  localparam int PTR_W = $clog2(N_WAYS);
  localparam int MAT_W = N_WAYS * N_WAYS;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [SET_W-1:0]  cnt_r;
  logic              init_wr_s, run_s, init_last_s;
  logic              query_s, touch_s;
  logic [N_WAYS-1:0] touch_oh_s, vict_s;
  logic              vict_vld_r, init_done_r;
  logic [N_WAYS-1:0] vict_way_r;

  function automatic logic [N_WAYS-1:0] lowest_bit(input logic [N_WAYS-1:0] v);
    return v & (~v + N_WAYS'(1'b1));
  endfunction

  // Matrix bit r*N_WAYS+c set means way r was used more recently than way c
  function automatic logic [MAT_W-1:0] lru_init();
    logic [MAT_W-1:0] res;
    res = '0;
    for (int r = 0; r < N_WAYS; r++) begin
      for (int c = 0; c < N_WAYS; c++) begin
        res[r*N_WAYS+c] = (r < c) ? 1'b1 : 1'b0;
      end
    end
    return res;
  endfunction

  function automatic logic [MAT_W-1:0] lru_touch(input logic [MAT_W-1:0] mat,
                                                 input logic [N_WAYS-1:0] oh);
    logic [MAT_W-1:0] res;
    res = mat;
    for (int r = 0; r < N_WAYS; r++) begin
      for (int c = 0; c < N_WAYS; c++) begin
        if (r == c) res[r*N_WAYS+c] = 1'b0;
        else if (oh[r]) res[r*N_WAYS+c] = 1'b1;
        else if (oh[c]) res[r*N_WAYS+c] = 1'b0;
        else res[r*N_WAYS+c] = mat[r*N_WAYS+c];
      end
    end
    return res;
  endfunction

  // A way is a candidate when no other unlocked way is older than it
  function automatic logic [N_WAYS-1:0] lru_pick(input logic [MAT_W-1:0] mat,
                                                 input logic [N_WAYS-1:0] lk);
    logic [N_WAYS-1:0] res, row;
    res = '0;
    for (int v = 0; v < N_WAYS; v++) begin
      row    = mat[v*N_WAYS +: N_WAYS] & ~lk;
      row[v] = 1'b0;
      res[v] = ~lk[v] & ~(|row);
    end
    return res;
  endfunction

  // Returns {found, index} of the first unlocked way scanning upward from p with wrap
  function automatic logic [PTR_W:0] rr_scan(input logic [PTR_W-1:0] p,
                                            input logic [N_WAYS-1:0] lk);
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] idx;
    res = '0;
    idx = p;
    for (int k = 0; k < N_WAYS; k++) begin
      if (!res[PTR_W] && !lk[idx]) res = {1'b1, idx};
      else res = res;
      idx = (idx == PTR_W'(N_WAYS - 1)) ? '0 : idx + PTR_W'(1'b1);
    end
    return res;
  endfunction

  assign init_last_s = (cnt_r == SET_W'(N_SETS - 1));
  assign touch_oh_s  = lowest_bit(TOUCH_WAY);
  assign query_s     = run_s & ENB & VICT_REQ;
  assign touch_s     = run_s & ENB & TOUCH_VLD & (|TOUCH_WAY);

  // FSM state register and initialisation sweep counter
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (init_wr_s) cnt_r <= cnt_r + SET_W'(1'b1);
      else cnt_r <= cnt_r;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_last_s) state_nxt_s = ST_RUN;
        else state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM output decode
  always_comb begin
    init_wr_s = 1'b0;
    run_s     = 1'b0;
    case (state_r)
      ST_INIT: init_wr_s = 1'b1;
      ST_RUN:  run_s = 1'b1;
      default: begin
        init_wr_s = 1'b0;
        run_s     = 1'b0;
      end
    endcase
  end

  // Registered query response and init-complete flag
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vict_vld_r  <= 1'b0;
      vict_way_r  <= '0;
      init_done_r <= 1'b0;
    end else begin
      vict_vld_r <= query_s;
      if (query_s) vict_way_r <= vict_s;
      else vict_way_r <= vict_way_r;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  generate
    if (MODE == 0) begin : g_lru
      logic [MAT_W-1:0] mat_r [N_SETS];

      assign vict_s = lowest_bit(lru_pick(mat_r[VICT_SET], LOCK));

      // Matrix storage: sweep-initialised, then updated by touches (read side sees pre-touch state)
      always_ff @(posedge CLK) begin
        if (init_wr_s) mat_r[cnt_r] <= lru_init();
        else if (touch_s) mat_r[TOUCH_SET] <= lru_touch(mat_r[TOUCH_SET], touch_oh_s);
      end
    end else begin : g_rr
      logic [PTR_W-1:0] ptr_r [N_SETS];
      logic [PTR_W:0]   scan_s;
      logic [PTR_W-1:0] nxt_ptr_s;
      logic             touch_unused_s;

      assign scan_s         = rr_scan(ptr_r[VICT_SET], LOCK);
      assign vict_s         = scan_s[PTR_W] ? (N_WAYS'(1'b1) << scan_s[PTR_W-1:0]) : '0;
      assign nxt_ptr_s      = (scan_s[PTR_W-1:0] == PTR_W'(N_WAYS - 1)) ? '0
                              : scan_s[PTR_W-1:0] + PTR_W'(1'b1);
      assign touch_unused_s = ^{touch_s, TOUCH_SET, touch_oh_s};

      // Pointer storage: advances past each granted victim; an all-locked query leaves it
      always_ff @(posedge CLK) begin
        if (init_wr_s) ptr_r[cnt_r] <= '0;
        else if (query_s && scan_s[PTR_W]) ptr_r[VICT_SET] <= nxt_ptr_s;
      end
    end
  endgenerate

  assign VICT_VLD  = vict_vld_r;
  assign VICT_WAY  = vict_way_r;
  assign INIT_DONE = init_done_r;

endmodule

// File: doc/repl_policy_array.md
REPL_POLICY_ARRAY -- requirements
Module: repl_policy_array

Interface
REQ-001 SHALL have parameter N_WAYS, default 4, number of ways per set (2..8).
REQ-002 SHALL have parameter N_SETS, default 64, number of sets tracked (power of two, >=2).
REQ-003 SHALL have parameter MODE, default 0, replacement mode: 0 = true LRU (precedence matrix), 1 = round-robin.
REQ-004 SHALL derive SET_W = ceil(log2(N_SETS)) internally; SET_W is not a parameter.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RSTN  input  1  reset, asynchronous, active-low.
REQ-007 ENB  input  1  global enable; low freezes policy state and ignores requests.
REQ-008 TOUCH_VLD  input  1  access-update strobe.
REQ-009 TOUCH_SET  input  SET_W  set index of the access.
REQ-010 TOUCH_WAY  input  N_WAYS  one-hot way accessed.
REQ-011 VICT_REQ  input  1  victim query strobe.
REQ-012 VICT_SET  input  SET_W  set index queried.
REQ-013 LOCK  input  N_WAYS  ways excluded from victim selection, bit i = way i.
REQ-014 VICT_VLD  output  1  VICT_WAY valid, one-cycle pulse.
REQ-015 VICT_WAY  output  N_WAYS  one-hot victim, all-zero if no eligible way.
REQ-016 INIT_DONE  output  1  high once the state-array initialisation sweep has completed.

Function
REQ-017 SHALL have FSM states INIT and RUN; INIT walks set counter 0..N_SETS-1, one set per cycle, writing the initial state, then enters RUN and raises INIT_DONE the following cycle; INIT takes exactly N_SETS cycles after RSTN release, independent of ENB.
REQ-018 In INIT, TOUCH_VLD and VICT_REQ SHALL be ignored and VICT_VLD held 0.
REQ-019 MODE 0 state per set: N_WAYS x N_WAYS bits, m[r][c]=1 means way r more recent than way c; initial m[r][c]=1 iff r<c (way 0 MRU, way N_WAYS-1 LRU).
REQ-020 MODE 0 touch of way w (RUN, ENB=1, TOUCH_VLD=1): row w set to 1 except diagonal, column w cleared, other bits unchanged.
REQ-021 MODE 0 victim: the unlocked way v with m[v][c]=0 for every unlocked c!=v; VICT_REQ does not alter state.
REQ-022 MODE 1 state per set: way pointer p, initial 0; victim = first unlocked way scanning p, p+1, ... modulo N_WAYS; on a non-zero result p becomes (victim index + 1) mod N_WAYS; touches do not alter state.
REQ-023 TOUCH_WAY all-zero SHALL cause no update; multiple bits set SHALL use only the lowest set bit.
REQ-024 VICT_VLD and VICT_WAY SHALL be registered: asserted exactly one cycle after VICT_REQ is sampled with ENB=1 in RUN; VICT_VLD low otherwise; VICT_WAY holds its last value when VICT_VLD=0.
REQ-025 LOCK all-ones (all ways locked) SHALL return VICT_VLD=1, VICT_WAY=0 and SHALL NOT move the MODE 1 pointer.
REQ-026 Same-cycle touch and query of the same set SHALL return the victim from pre-touch state; the touch still applies.
REQ-027 Accepts one touch and one query per cycle, no back-pressure; different sets never interact.
REQ-028 ENB=0 SHALL hold all policy state and produce VICT_VLD=0 next cycle.

Reset
REQ-029 RSTN low SHALL immediately force FSM=INIT, set counter=0, INIT_DONE=0, VICT_VLD=0, VICT_WAY=0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL discard progress; the full N_SETS sweep restarts on release and all sets return to initial state.

Verification (N_WAYS=4, N_SETS=8)
REQ-031 Release RSTN -> INIT_DONE rises after exactly 8 cycles; VICT_REQ set 3, LOCK=0 -> next cycle VICT_VLD=1, VICT_WAY=4'b1000.
REQ-032 MODE 0: touch set 5 way 3 then way 1, query set 5 -> 4'b0100; touch way 2, query -> 4'b0001; set 4 query -> 4'b1000.
REQ-033 MODE 0: query set 0 LOCK=4'b1000 -> 4'b0100; LOCK=4'b1111 -> VICT_VLD=1, VICT_WAY=4'b0000.
REQ-034 MODE 0: same cycle touch set 2 way 3 and query set 2 -> 4'b1000; next query -> 4'b0100.
REQ-035 MODE 1: three queries set 1 LOCK=0 -> 4'b0001, 4'b0010, 4'b0100; after reset, LOCK=4'b0010 twice -> 4'b0001, 4'b0100.
REQ-036 RSTN pulsed low mid-RUN after touches -> VICT_VLD, VICT_WAY, INIT_DONE at 0 without clock edge; after 8-cycle sweep, query set 5 -> 4'b1000; ENB=0 with VICT_REQ -> VICT_VLD stays 0.
